// File: rtl/timer_nbit_apb.sv
// N-bit up/down timer with prescaled tick, reload, compare and level interrupt,
// on a zero-wait-state APB slave.
`timescale 1ns/1ps
module timer_nbit_apb #(
  parameter int WIDTH    = 16,
  parameter int PSC_BITS = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [7:0]       paddr,
  input  logic [WIDTH-1:0] pwdata,
  output logic [WIDTH-1:0] prdata,
  output logic             pready,
  output logic             pslverr,
  output logic             irq
);

  localparam int CKS_MAX = (PSC_BITS - 1 > 7) ? 7 : PSC_BITS - 1;

  logic [WIDTH-1:0]    tdr, tcnt, tcmp, tcnt_nxt;
  logic                tcr_load, tcr_arl, tcr_down, tcr_en;
  logic [2:0]          tcr_cks, tsr, tier, tsr_set, tsr_nxt;
  logic [PSC_BITS-1:0] psc;
  logic                wr, rd, mapped, tick;
  logic [7:0]          tcr_rd;

  assign wr     = psel & penable & pwrite;
  assign rd     = psel & penable & ~pwrite & ~preset;
  assign mapped = (paddr <= 8'h05);
  assign pready = 1'b1;
  assign pslverr = psel & penable & ~mapped & ~preset;
  assign tcr_rd = {tcr_load, tcr_arl, tcr_down, tcr_en, 1'b0, tcr_cks};

  // Tick when the low cks+1 prescaler bits are all ones; cks saturates at the prescaler width.
  always_comb begin
    int cks_eff;
    cks_eff = (int'(tcr_cks) > CKS_MAX) ? CKS_MAX : int'(tcr_cks);
    tick = 1'b1;
    for (int i = 0; i < PSC_BITS; i++) begin
      if (i <= cks_eff && !psc[i]) tick = 1'b0;
    end
  end

  always_comb begin
    tcnt_nxt = tcnt;
    tsr_set  = 3'b000;
    if (tcr_load) begin
      tcnt_nxt = tdr;
    end else if (tcr_en && tick) begin
      if (!tcr_down) begin
        if (tcnt == '1) begin
          tsr_set[0] = 1'b1;
          tcnt_nxt   = tcr_arl ? tdr : '0;
        end else begin
          tcnt_nxt = tcnt + WIDTH'(1);
        end
      end else begin
        if (tcnt == '0) begin
          tsr_set[1] = 1'b1;
          tcnt_nxt   = tcr_arl ? tdr : '1;
        end else begin
          tcnt_nxt = tcnt - WIDTH'(1);
        end
      end
      if (tcnt_nxt == tcmp) tsr_set[2] = 1'b1;
    end
  end

  // Software writes 0 to clear; a same-cycle hardware set wins.
  always_comb begin
    tsr_nxt = tsr;
    if (wr && paddr == 8'h02) tsr_nxt = tsr & pwdata[2:0];
    tsr_nxt = tsr_nxt | tsr_set;
  end

  always_comb begin
    prdata = '0;
    if (rd) begin
      case (paddr)
        8'h00:   prdata = tdr;
        8'h01:   prdata = WIDTH'(tcr_rd);
        8'h02:   prdata = WIDTH'(tsr);
        8'h03:   prdata = tcnt;
        8'h04:   prdata = tcmp;
        8'h05:   prdata = WIDTH'(tier);
        default: prdata = '0;
      endcase
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tdr      <= '0;
      tcmp     <= '0;
      tcnt     <= '0;
      tcr_load <= 1'b0;
      tcr_arl  <= 1'b0;
      tcr_down <= 1'b0;
      tcr_en   <= 1'b0;
      tcr_cks  <= 3'b000;
      tsr      <= 3'b000;
      tier     <= 3'b000;
      psc      <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr) begin
        case (paddr)
          8'h00: tdr <= pwdata;
          8'h01: begin
            {tcr_load, tcr_arl, tcr_down, tcr_en} <= pwdata[7:4];
            tcr_cks <= pwdata[2:0];
          end
          8'h04: tcmp <= pwdata;
          8'h05: tier <= pwdata[2:0];
          default: ;
        endcase
      end
      tsr  <= tsr_nxt;
      tcnt <= tcnt_nxt;
      psc  <= tcr_en ? psc + PSC_BITS'(1) : '0;
      irq  <= |(tsr & tier);
    end
  end

endmodule

// File: tb/tb_timer_nbit_apb.sv
// Scoreboard bench for timer_nbit_apb: a 16-bit and an 8-bit instance share the APB bus,
// each selected by its own psel; reads push expectations, a monitor pops and compares.
`timescale 1ns/1ps
module tb_timer_nbit_apb;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel16 = 1'b0, psel8 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = 8'h00;
  logic [15:0] pwdata = 16'h0000;
  logic [15:0] prdata16;
  logic [7:0]  prdata8;
  logic        pready16, pready8, pslverr16, pslverr8, irq16, irq8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] exp;
    logic [15:0] mask;
    logic        exp_err;
    logic        chk_irq;
    logic        exp_irq;
    string       name;
  } item_t;
  item_t sb[$];

  always #5 pclk = ~pclk;

  timer_nbit_apb #(.WIDTH(16), .PSC_BITS(8)) dut16 (
    .pclk(pclk), .preset(preset), .psel(psel16), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata16), .pready(pready16),
    .pslverr(pslverr16), .irq(irq16)
  );

  timer_nbit_apb #(.WIDTH(8), .PSC_BITS(8)) dut8 (
    .pclk(pclk), .preset(preset), .psel(psel8), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata[7:0]), .prdata(prdata8), .pready(pready8),
    .pslverr(pslverr8), .irq(irq8)
  );

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: every read access phase pops one expectation.
  always @(negedge pclk) begin
    if ((psel16 || psel8) && penable && !pwrite) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 16'h0001, 16'h0000);
      end else begin
        item_t it;
        logic [15:0] d;
        it = sb.pop_front();
        d  = psel16 ? prdata16 : {8'h00, prdata8};
        chk(it.name, d & it.mask, it.exp & it.mask);
        chk({it.name, "_pslverr"}, {15'h0, psel16 ? pslverr16 : pslverr8}, {15'h0, it.exp_err});
        chk({it.name, "_pready"}, {15'h0, psel16 ? pready16 : pready8}, 16'h0001);
        if (it.chk_irq)
          chk({it.name, "_irq"}, {15'h0, psel16 ? irq16 : irq8}, {15'h0, it.exp_irq});
      end
    end
  end

  // All tasks start and end 1ns after a rising edge; one transfer takes two cycles.
  task automatic wr(input bit d8, input logic [7:0] a, input logic [15:0] d);
    psel16 = !d8; psel8 = d8; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel16 = 1'b0; psel8 = 1'b0; penable = 1'b0;
  endtask

  task automatic rd(input bit d8, input logic [7:0] a, input logic [15:0] exp,
                    input logic [15:0] mask, input bit exp_err, input bit ci, input bit ei,
                    input string nm);
    item_t it;
    it.exp = exp; it.mask = mask; it.exp_err = exp_err; it.chk_irq = ci; it.exp_irq = ei;
    it.name = nm;
    sb.push_back(it);
    psel16 = !d8; psel8 = d8; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel16 = 1'b0; psel8 = 1'b0; penable = 1'b0;
  endtask

  task automatic r16(input logic [7:0] a, input logic [15:0] exp, input string nm);
    rd(1'b0, a, exp, 16'hFFFF, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic pulse_reset();
    #2 preset = 1'b1;
    #12 preset = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;

    // Reset state and register map
    for (int i = 0; i < 6; i++) rd(1'b0, 8'(i), 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, "reset_reg");
    wr(0, 8'h01, 16'hFFFF);  r16(8'h01, 16'h00F7, "tcr_bits");
    wr(0, 8'h05, 16'hFFFF);  r16(8'h05, 16'h0007, "tier_bits");
    wr(0, 8'h02, 16'hFFFF);  r16(8'h02, 16'h0000, "tsr_write1_noop");
    wr(0, 8'h00, 16'hA5A5);  r16(8'h00, 16'hA5A5, "tdr_rw");
    r16(8'h03, 16'hA5A5, "tcnt_load");
    wr(0, 8'h04, 16'h5A5A);  r16(8'h04, 16'h5A5A, "tcmp_rw");
    wr(0, 8'h06, 16'h1234);  rd(1'b0, 8'h06, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, "unmapped");
    pulse_reset();

    // Down count from 3 with /2 tick: underflow wraps to all-ones
    wr(0, 8'h04, 16'h1234); wr(0, 8'h00, 16'h0003);
    wr(0, 8'h01, 16'h0080); wr(0, 8'h01, 16'h0030);
    r16(8'h03, 16'h0003, "dn_3"); r16(8'h03, 16'h0002, "dn_2");
    r16(8'h03, 16'h0001, "dn_1"); r16(8'h03, 16'h0000, "dn_0");
    r16(8'h03, 16'hFFFF, "dn_wrap");
    r16(8'h02, 16'h0002, "dn_udf");
    pulse_reset();

    // Auto-reload up count from 0xFFFE
    wr(0, 8'h04, 16'h1234); wr(0, 8'h00, 16'hFFFE);
    wr(0, 8'h01, 16'h00C0); wr(0, 8'h01, 16'h0050);
    r16(8'h03, 16'hFFFE, "arl_a"); r16(8'h03, 16'hFFFF, "arl_b");
    r16(8'h03, 16'hFFFE, "arl_c"); r16(8'h03, 16'hFFFF, "arl_d");
    r16(8'h03, 16'hFFFE, "arl_e");
    r16(8'h02, 16'h0001, "arl_ovf");
    pulse_reset();

    // Software clear lands on the same edge as an overflow set
    wr(0, 8'h04, 16'h1234); wr(0, 8'h00, 16'hFFFE);
    wr(0, 8'h01, 16'h00C0); wr(0, 8'h01, 16'h0050);
    idle(2);
    wr(0, 8'h02, 16'h0000);
    wr(0, 8'h01, 16'h0000);
    r16(8'h02, 16'h0001, "ovf_beats_clear");
    r16(8'h03, 16'hFFFF, "hold_disabled");

    // Reset mid-count with interrupt pending
    wr(0, 8'h05, 16'h0001);
    rd(1'b0, 8'h05, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b1, "irq_ovf");
    wr(0, 8'h01, 16'h0010);
    idle(5);
    pulse_reset();
    for (int i = 0; i < 6; i++) rd(1'b0, 8'(i), 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, "post_reset");
    rd(1'b0, 8'h07, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, "unmapped_07");

    // Write abandoned by reset during its access phase
    psel16 = 1'b1; pwrite = 1'b1; paddr = 8'h00; pwdata = 16'h5555; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    #2 preset = 1'b1;
    @(posedge pclk); #2 preset = 1'b0; psel16 = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    r16(8'h00, 16'h0000, "abandoned_wr");
    wr(0, 8'h00, 16'h0042); r16(8'h00, 16'h0042, "wr_after_reset");
    pulse_reset();

    // Compare at 0x0010 with /2 tick from 0 raises irq
    wr(0, 8'h04, 16'h0010); wr(0, 8'h05, 16'h0004); wr(0, 8'h01, 16'h0010);
    rd(1'b0, 8'h02, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, "cmp_early");
    idle(28);
    rd(1'b0, 8'h02, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, "cmp_before");
    rd(1'b0, 8'h02, 16'h0004, 16'hFFFF, 1'b0, 1'b1, 1'b1, "cmp_set");
    r16(8'h03, 16'h0011, "cmp_cnt");
    wr(0, 8'h01, 16'h0000);
    wr(0, 8'h02, 16'h0000);
    chk("irq_one_cycle_lag", {15'h0, irq16}, 16'h0001);
    rd(1'b0, 8'h02, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0, "cmp_cleared");

    // 8-bit instance: up /8 from 0 overflows after 2048 pclk
    wr(1, 8'h01, 16'h0012);
    idle(1996);
    rd(1'b1, 8'h02, 16'h0000, 16'h00FF, 1'b0, 1'b0, 1'b0, "w8_no_ovf");
    idle(60);
    rd(1'b1, 8'h02, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0, "w8_ovf");
    // TCMP=0 is also reached on the wrap tick
    rd(1'b1, 8'h02, 16'h0004, 16'h0004, 1'b0, 1'b0, 1'b0, "w8_cmp_on_wrap");
    wr(1, 8'h02, 16'h0000);
    rd(1'b1, 8'h02, 16'h0000, 16'h00FF, 1'b0, 1'b0, 1'b0, "w8_cleared");
    wr(1, 8'h01, 16'h0000);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge pclk);
    if (sb.size() != 0) chk("scoreboard_drain", 16'(sb.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
